uart_fifo: RTL and testbench

- Parametrised 16x-oversampled UART for the MIPS IO peripheral bus; successor to the fixed 8-bit, single-buffer UART.
- Adds configurable data width, parity mode and stop-bit count.
- Adds receive and transmit FIFOs with full/empty status and a sticky overrun flag.
- CPU side uses active-low rdn/wrn strobes; serial side is rxd/txd at clk16x/16 baud.

---
 rtl/uart_fifo_pkg.sv | 20 ++
 rtl/uart_sync_fifo.sv | 44 ++++
 rtl/uart_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants and state encoding for the buffered 16x-oversampled UART.
package uart_fifo_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Start bit is checked at its centre; every later bit is 16 ticks on.
  localparam logic [3:0] SAMPLE_MID = 4'd7;
  localparam logic [3:0] BIT_LAST   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk16x,
  input  logic                     clrn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk16x) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_fifo.sv
// 16x-oversampled UART with configurable framing and RX/TX FIFOs on the CPU side.
module uart_fifo import uart_fifo_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk16x,
  input  logic                 clrn,
  input  logic                 rdn,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 r_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun,
  output logic [CW-1:0]        r_count,
  input  logic                 rxd,
  input  logic                 wrn,
  input  logic [DATA_BITS-1:0] d_in,
  output logic                 t_full,
  output logic                 t_empty,
  output logic                 txd
);

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~(^d) : ^d;
  endfunction

  logic rdn_s1_q, rdn_s2_q, rdn_prev_q, wrn_s1_q, wrn_s2_q, wrn_prev_q;
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic rd_fire, wr_fire;

  uart_state_e          rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [3:0]           rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic                 rx_perr_q, rx_perr_d, tx_par_q, tx_par_d;
  logic                 txd_q, txd_d, overrun_q, rx_push, tx_pop;

  logic [DATA_BITS+1:0] rx_head;
  logic                 rx_full, rx_empty, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic [CW-1:0]        tx_count;

  assign rd_fire = rdn_prev_q && !rdn_s2_q;
  assign wr_fire = wrn_prev_q && !wrn_s2_q;

  uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk16x (clk16x), .clrn (clrn),
    .push_i (rx_push), .wdata_i ({~rxd_s2_q, rx_perr_q, rx_shift_q}),
    .pop_i  (rd_fire), .rdata_o (rx_head),
    .full_o (rx_full), .empty_o (rx_empty), .count_o (r_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk16x (clk16x), .clrn (clrn),
    .push_i (wr_fire), .wdata_i (d_in),
    .pop_i  (tx_pop), .rdata_o (tx_head),
    .full_o (tx_full), .empty_o (tx_empty), .count_o (tx_count)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 4'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    unique case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_prev_q && !rxd_s2_q) rx_state_d = ST_START;
      end
      ST_START: if (rx_cnt_q == SAMPLE_MID) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_perr_d  = 1'b0;
        rx_state_d = rxd_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_shift_d = {rxd_s2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'(DATA_BITS - 1)) begin
          rx_bit_d   = '0;
          rx_state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (rx_cnt_q == BIT_LAST) begin
        rx_perr_d  = rxd_s2_q ^ par_bit(rx_shift_q);
        rx_state_d = ST_STOP;
      end
      ST_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_push    = 1'b1;
        rx_state_d = ST_IDLE;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 4'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_par_d   = par_bit(tx_head);
          tx_state_d = ST_START;
        end
      end
      ST_START: if (tx_cnt_q == BIT_LAST) begin
        tx_bit_d   = '0;
        tx_state_d = ST_DATA;
      end
      ST_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'(DATA_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (tx_cnt_q == BIT_LAST) begin
        tx_bit_d   = '0;
        tx_state_d = ST_STOP;
      end
      ST_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'(STOP_BITS - 1)) tx_state_d = ST_IDLE;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // txd is registered from next-state so the line never glitches.
    unique case (tx_state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = tx_shift_d[0];
      ST_PARITY: txd_d = tx_par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      {rdn_s1_q, rdn_s2_q, rdn_prev_q} <= 3'b111;
      {wrn_s1_q, wrn_s2_q, wrn_prev_q} <= 3'b111;
      {rxd_s1_q, rxd_s2_q, rxd_prev_q} <= 3'b111;
      rx_state_q <= ST_IDLE;
      tx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      {rdn_s1_q, rdn_s2_q, rdn_prev_q} <= {rdn, rdn_s1_q, rdn_s2_q};
      {wrn_s1_q, wrn_s2_q, wrn_prev_q} <= {wrn, wrn_s1_q, wrn_s2_q};
      {rxd_s1_q, rxd_s2_q, rxd_prev_q} <= {rxd, rxd_s1_q, rxd_s2_q};
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
      if (rx_push && rx_full)      overrun_q <= 1'b1;
      else if (rd_fire && !rx_empty) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk16x) begin
    rx_shift_q <= rx_shift_d;
    rx_perr_q  <= rx_perr_d;
    tx_shift_q <= tx_shift_d;
    tx_par_q   <= tx_par_d;
  end

  assign r_ready      = !rx_empty;
  assign d_out        = r_ready ? rx_head[DATA_BITS-1:0] : '0;
  assign parity_error = r_ready & rx_head[DATA_BITS];
  assign frame_error  = r_ready & rx_head[DATA_BITS+1];
  assign overrun      = overrun_q;
  assign t_full       = tx_full;
  assign t_empty      = (tx_count == '0) && (tx_state_q == ST_IDLE);
  assign txd          = txd_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Randomised scenario bench for uart_fifo (8 data bits, even parity, 1 stop, depth 4).
module tb_uart_fifo;
  localparam int CW = 3;

  logic          clk16x = 1'b0;
  logic          clrn = 1'b0, rdn = 1'b1, wrn = 1'b1;
  logic          rxd_drv = 1'b1, loop = 1'b1;
  logic [7:0]    d_in = '0, d_out;
  logic          r_ready, parity_error, frame_error, overrun, t_full, t_empty, txd, rxd;
  logic [CW-1:0] r_count;

  int vectors = 0;
  int errors  = 0;

  assign rxd = loop ? txd : rxd_drv;

  uart_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk16x(clk16x), .clrn(clrn), .rdn(rdn), .d_out(d_out), .r_ready(r_ready),
    .parity_error(parity_error), .frame_error(frame_error), .overrun(overrun),
    .r_count(r_count), .rxd(rxd), .wrn(wrn), .d_in(d_in), .t_full(t_full),
    .t_empty(t_empty), .txd(txd)
  );

  always #5 clk16x = ~clk16x;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return logic'(ones % 2);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk16x);
  endtask

  task automatic cpu_write(input logic [7:0] d);
    @(negedge clk16x);
    d_in = d; wrn = 1'b0;
    tick(4);
    wrn = 1'b1;
    tick(4);
  endtask

  task automatic cpu_read();
    @(negedge clk16x);
    rdn = 1'b0;
    tick(4);
    rdn = 1'b1;
    tick(4);
  endtask

  task automatic wait_rready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (r_ready) begin ok = 1'b1; return; end
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
    @(negedge clk16x);
    rxd_drv = 1'b0; tick(16);
    for (int i = 0; i < 8; i++) begin rxd_drv = d[i]; tick(16); end
    rxd_drv = pbit; tick(16);
    rxd_drv = sbit; tick(16);
    rxd_drv = 1'b1; tick(4);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    tick(3);
    vectors++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
    vectors++; if (d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out got %h want 00", d_out); end
    vectors++; if (r_ready !== 1'b0) begin errors++; $display("FAIL reset_r_ready got %b want 0", r_ready); end
    vectors++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_error); end
    vectors++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_error); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    vectors++; if (r_count !== 3'd0) begin errors++; $display("FAIL reset_r_count got %0d want 0", r_count); end
    vectors++; if (t_full !== 1'b0) begin errors++; $display("FAIL reset_t_full got %b want 0", t_full); end
    vectors++; if (t_empty !== 1'b1) begin errors++; $display("FAIL reset_t_empty got %b want 1", t_empty); end
    clrn = 1'b1;
    tick(4);
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    bit ok;
    loop = 1'b1;
    for (int n = 0; n < 6; n++) begin
      b = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      cpu_write(b);
      wait_rready(400, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL loopback_timeout byte %h got r_ready 0 want 1", b); end
      vectors++; if (d_out !== b) begin errors++; $display("FAIL loopback_data got %h want %h", d_out, b); end
      vectors++; if (parity_error !== 1'b0) begin errors++; $display("FAIL loopback_perr got %b want 0", parity_error); end
      vectors++; if (frame_error !== 1'b0) begin errors++; $display("FAIL loopback_ferr got %b want 0", frame_error); end
      cpu_read();
      vectors++; if (r_ready !== 1'b0) begin errors++; $display("FAIL loopback_pop got r_ready %b want 0", r_ready); end
    end
  endtask

  // One byte sits in the shifter, four fill the FIFO, the sixth write is dropped.
  task automatic test_burst();
    logic [7:0] q[$];
    bit ok;
    loop = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      cpu_write(8'(b));
      q.push_back(8'(b));
    end
    vectors++; if (t_full !== 1'b1) begin errors++; $display("FAIL burst_full got %b want 1", t_full); end
    cpu_write(8'h06);
    vectors++; if (t_full !== 1'b1) begin errors++; $display("FAIL burst_full_after_drop got %b want 1", t_full); end
    while (q.size() > 0) begin
      wait_rready(400, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL burst_timeout got r_ready 0 want 1"); end
      vectors++; if (d_out !== q[0]) begin errors++; $display("FAIL burst_order got %h want %h", d_out, q[0]); end
      void'(q.pop_front());
      cpu_read();
    end
    tick(300);
    vectors++; if (r_count !== 3'd0) begin errors++; $display("FAIL burst_drop got r_count %0d want 0", r_count); end
    vectors++; if (t_empty !== 1'b1) begin errors++; $display("FAIL burst_t_empty got %b want 1", t_empty); end
  endtask

  task automatic test_overrun();
    logic [7:0] data[5];
    loop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data[i] = 8'($urandom_range(0, 255));
      send_frame(data[i], even_par(data[i]), 1'b1);
    end
    vectors++; if (r_count !== 3'd4) begin errors++; $display("FAIL overrun_count got %0d want 4", r_count); end
    vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (d_out !== data[i]) begin errors++; $display("FAIL overrun_data%0d got %h want %h", i, d_out, data[i]); end
      cpu_read();
      if (i == 0) begin
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", overrun); end
      end
    end
    vectors++; if (r_count !== 3'd0) begin errors++; $display("FAIL overrun_drain got %0d want 0", r_count); end
  endtask

  task automatic test_errors();
    logic [7:0] d;
    logic pb, sb;
    loop = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n == 0)      begin d = 8'h3C; pb = 1'b1; sb = 1'b1; end
      else if (n == 1) begin d = 8'h3C; pb = 1'b0; sb = 1'b0; end
      else begin
        d  = 8'($urandom_range(0, 255));
        pb = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
      end
      send_frame(d, pb, sb);
      vectors++; if (r_ready !== 1'b1) begin errors++; $display("FAIL err_ready got %b want 1", r_ready); end
      vectors++; if (d_out !== d) begin errors++; $display("FAIL err_data got %h want %h", d_out, d); end
      vectors++; if (parity_error !== (pb != even_par(d))) begin errors++;
        $display("FAIL err_parity data %h pbit %b got %b want %b", d, pb, parity_error, pb != even_par(d)); end
      vectors++; if (frame_error !== !sb) begin errors++;
        $display("FAIL err_frame data %h stop %b got %b want %b", d, sb, frame_error, !sb); end
      cpu_read();
    end
  endtask

  task automatic test_false_start();
    loop = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk16x);
      rxd_drv = 1'b0;
      tick((n == 0) ? 4 : $urandom_range(1, 5));
      rxd_drv = 1'b1;
      tick(200);
      vectors++; if (r_count !== 3'd0) begin errors++; $display("FAIL false_start got r_count %0d want 0", r_count); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    bit ok;
    loop = 1'b1;
    cpu_write(8'($urandom_range(0, 255)));
    tick(60);
    #2 clrn = 1'b0;
    #1;
    vectors++; if (txd !== 1'b1) begin errors++; $display("FAIL midreset_txd got %b want 1", txd); end
    vectors++; if (t_empty !== 1'b1) begin errors++; $display("FAIL midreset_t_empty got %b want 1", t_empty); end
    @(negedge clk16x);
    clrn = 1'b1;
    tick(4);
    b = 8'($urandom_range(0, 255));
    cpu_write(b);
    wait_rready(400, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL midreset_timeout got r_ready 0 want 1"); end
    vectors++; if (d_out !== b) begin errors++; $display("FAIL midreset_data got %h want %h", d_out, b); end
    vectors++; if (parity_error !== 1'b0 || frame_error !== 1'b0) begin errors++;
      $display("FAIL midreset_flags got %b%b want 00", parity_error, frame_error); end
    vectors++; if (r_count !== 3'd1) begin errors++; $display("FAIL midreset_count got %0d want 1", r_count); end
    cpu_read();
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_burst();
    test_overrun();
    test_errors();
    test_false_start();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
